display_source_arbiter: RTL
===========================

# display_source_arbiter

Shares the 4-digit multiplexed 7-segment display between up to `N_SRC` independent requesters, such as a counter value, a status code or an error code. It time-slices the display round-robin with a fixed dwell time, lets urgent requesters pre-empt, and inserts a blank gap between sources to avoid ghosting. Its registered `D0..D3` outputs feed the scanning display decoder directly; its `BLANK` output lets the top level force all digits off.

## Interface
- `N_SRC`, default 4: number of requesters, 2..8.
- `DWELL_CYCLES`, default 50_000_000: clocks a source is shown per turn, ≥2.
- `GAP_CYCLES`, default 500_000: blank clocks between two different sources, ≥1.
- `CLK  in  1`: single clock; all state on rising edge.
- `RST  in  1`: asynchronous, active-high reset.
- `REQ  in  N_SRC`: source i wants the display, level-sensitive.
- `URGENT  in  N_SRC`: source i requests pre-emption; ignored unless `REQ[i]` is also high.
- `FRAME  in  16*N_SRC`: 4 BCD digits per source. Source i occupies `[16i+15:16i]`; digit 0 is at the LSBs.
- `D0, D1, D2, D3  out  4 each`: digit values for the decoder, registered.
- `GRANT  out  N_SRC`: one-hot index of the source being shown; all-zero when none.
- `BLANK  out  1`: high when no source is shown.
- `SWITCH  out  1`: one-cycle pulse on the first cycle of every new grant.

## Operation
- States: IDLE, SHOW, GAP. Reset enters IDLE.
- **IDLE**
  - `GRANT`=0, `BLANK`=1, `D0..D3`=0.
  - Any `REQ` → arbitrate, load dwell counter with `DWELL_CYCLES-1`, go to SHOW.
- **Arbitration**
  - Urgent requesters win first; among them, the lowest index wins.
  - Otherwise round-robin, starting at the index after the last granted source.
  - After reset the pointer makes source 0 the first candidate.
- **SHOW**
  - `BLANK`=0.
  - `D0..D3` reload every cycle from the granted source's `FRAME` slice.
  - Dwell counter decrements each cycle, saturating at 0.
- **Leaving SHOW**, priority order:
  1. Granted `REQ` falls → GAP.
  2. Another source has `REQ` and `URGENT` high while the granted source is not urgent → GAP immediately.
  3. Counter=0 and the granted source is urgent → stay; urgent holders are never time-sliced out.
  4. Counter=0 and another `REQ` is pending → GAP.
  5. Counter=0 and no other request → reload the counter and stay. No gap and no `SWITCH` pulse.
- **GAP**
  - `GRANT`=0, `BLANK`=1, `D0..D3`=0 for exactly `GAP_CYCLES` cycles; urgent requests do not shorten it.
  - At the end, arbitrate: any `REQ` → SHOW, otherwise IDLE.
- The round-robin pointer updates only when a grant is issued.
- Counter widths: `$clog2(DWELL_CYCLES)` for dwell and `$clog2(GAP_CYCLES+1)` for gap. Each counter is loaded with its cycle count minus 1.

## Timing
- All outputs are registered.
- Reset values: `GRANT`=0, `BLANK`=1, `D0..D3`=0, `SWITCH`=0. Internally, state=IDLE, pointer=N_SRC-1 and counters=0.
- `RST` asserting mid-operation clears all outputs asynchronously. The first grant after release follows the reset arbitration rules.
- Latency:
  - `REQ` rising in IDLE → `GRANT`/`D`/`SWITCH` valid on the next edge.
  - A `FRAME` change during SHOW → `D` updates on the next edge.
- A grant is held for exactly `DWELL_CYCLES` cycles when it expires normally.
- A drop or pre-emption detected at edge k → `GRANT`=0 from edge k.
- `REQ` and `URGENT` may change on any cycle. Simultaneous expiry and pre-emption resolve as pre-emption.

## Structure
- Package `display_pkg`:
  - typedef `bcd_t` (logic [3:0]);
  - enum `arb_state_t` {IDLE, SHOW, GAP};
  - function `frame_slice(frame, idx)`.
- Sub-module `rr_picker`: combinational. Inputs are request vector, urgent vector and pointer; outputs are one-hot grant and a valid flag.
- The FSM, counters and output registers live in `display_source_arbiter`.

## Test plan
All scenarios use N_SRC=4, DWELL_CYCLES=8, GAP_CYCLES=2.

- **Round-robin:** `REQ`=4'b0101 from reset → `GRANT`=0001 for 8 cycles, 2 blank cycles, 0100 for 8, 2 blank, 0001. `SWITCH` pulses at each grant.
- **Single source:** `REQ`=0010 steady, `FRAME[31:16]`=16'h1234 → `GRANT`=0010 continuously, no gaps, one `SWITCH`; `D3..D0`=1,2,3,4. Changing the slice to 16'h5678 → `D3..D0`=5,6,7,8 one cycle later.
- **Urgent pre-emption:** source 0 shown for 3 cycles, then `REQ[3]`=`URGENT[3]`=1 → `GRANT`=0 next edge, 2 blank cycles, `GRANT`=1000. It holds past 8 cycles while urgent; after `URGENT[3]` drops with `REQ[0]` still high, the grant moves to source 0 at the next expiry plus gap.
- **Requester drop:** source 2 shown, `REQ`→0 at cycle 4 → GAP for 2 cycles, then IDLE with `BLANK`=1 and `D0..D3`=0.
- **Reset mid-SHOW:** pulse `RST` while `GRANT`=0100 → outputs reach reset values without waiting for a clock edge. With `REQ`=1111 after release, source 0 is granted first.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display source arbiter.
package display_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {IDLE, SHOW, GAP} arb_state_t;

   localparam int unsigned MaxSrc    = 8;
   localparam int unsigned FrameMaxW = 16 * MaxSrc;

   // Four BCD digits of source idx; the frame is zero-extended to the widest configuration.
   function automatic logic [15:0] frame_slice(input logic [FrameMaxW-1:0] frame,
                                               input logic [2:0]           idx);
      return frame[{idx, 4'b0000} +: 16];
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational source picker: lowest-index urgent requester wins, else round-robin after ptr_i.
module rr_picker #(
   parameter int unsigned N_SRC = 4
) (
   input  logic [N_SRC-1:0]         req_i,
   input  logic [N_SRC-1:0]         urgent_i,
   input  logic [$clog2(N_SRC)-1:0] ptr_i,
   output logic [N_SRC-1:0]         grant_o,
   output logic                     valid_o
);

   localparam int unsigned IdxW = $clog2(N_SRC);

   logic [N_SRC-1:0] urg;
   logic [IdxW-1:0]  idx;

   always_comb begin
      urg     = req_i & urgent_i;
      grant_o = '0;
      idx     = '0;
      valid_o = |req_i;
      if (|urg) begin
         // Isolate the lowest set bit.
         grant_o = urg & (~urg + N_SRC'(1));
      end else begin
         // Walk from farthest to nearest so the candidate right after ptr_i wins last.
         for (int unsigned k = N_SRC; k >= 1; k--) begin
            idx = IdxW'((32'(ptr_i) + k) % N_SRC);
            if (req_i[idx]) begin
               grant_o      = '0;
               grant_o[idx] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/display_source_arbiter.sv
// Time-slices a 4-digit display between requesters with urgent pre-emption and blank gaps.
module display_source_arbiter
   import display_pkg::*;
#(
   parameter int unsigned N_SRC        = 4,
   parameter int unsigned DWELL_CYCLES = 50_000_000,
   parameter int unsigned GAP_CYCLES   = 500_000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N_SRC-1:0]     req_i,
   input  logic [N_SRC-1:0]     urgent_i,
   input  logic [16*N_SRC-1:0]  frame_i,
   output logic [3:0]           d0_o,
   output logic [3:0]           d1_o,
   output logic [3:0]           d2_o,
   output logic [3:0]           d3_o,
   output logic [N_SRC-1:0]     grant_o,
   output logic                 blank_o,
   output logic                 switch_o
);

   localparam int unsigned IdxW   = $clog2(N_SRC);
   localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
   localparam int unsigned GapW   = $clog2(GAP_CYCLES + 1);

   localparam logic [DwellW-1:0] DwellLoad = DwellW'(DWELL_CYCLES - 1);
   localparam logic [GapW-1:0]   GapLoad   = GapW'(GAP_CYCLES - 1);

   arb_state_t         state_q, state_d;
   logic [IdxW-1:0]    ptr_q, ptr_d;
   logic [DwellW-1:0]  dwell_q, dwell_d;
   logic [GapW-1:0]    gap_q, gap_d;
   logic [N_SRC-1:0]   grant_q, grant_d;
   logic               blank_q, blank_d;
   logic               switch_q, switch_d;
   bcd_t [3:0]         digits_q, digits_d;

   logic [N_SRC-1:0]     pick_gnt;
   logic                 pick_valid;
   logic [IdxW-1:0]      pick_idx;
   logic [FrameMaxW-1:0] frame_ext;
   logic                 cur_req, cur_urg, other_req, other_urg;
   logic                 do_grant, go_gap;

   rr_picker #(
      .N_SRC (N_SRC)
   ) u_picker (
      .req_i    (req_i),
      .urgent_i (urgent_i),
      .ptr_i    (ptr_q),
      .grant_o  (pick_gnt),
      .valid_o  (pick_valid)
   );

   assign frame_ext = FrameMaxW'(frame_i);

   // In SHOW the pointer always names the source on display.
   assign cur_req   = req_i[ptr_q];
   assign cur_urg   = urgent_i[ptr_q];
   assign other_req = |(req_i & ~grant_q);
   assign other_urg = |(req_i & urgent_i & ~grant_q);

   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (pick_gnt[i]) pick_idx = IdxW'(i);
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      dwell_d  = dwell_q;
      gap_d    = gap_q;
      grant_d  = grant_q;
      blank_d  = blank_q;
      switch_d = 1'b0;
      digits_d = digits_q;
      do_grant = 1'b0;
      go_gap   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) do_grant = 1'b1;
         end
         SHOW: begin
            digits_d = frame_slice(frame_ext, 3'(ptr_q));
            if (!cur_req) begin
               go_gap = 1'b1;
            end else if (other_urg && !cur_urg) begin
               go_gap = 1'b1;
            end else if (dwell_q == '0) begin
               // Urgent holders keep the display with a saturated counter.
               if (!cur_urg) begin
                  if (other_req) go_gap = 1'b1;
                  else           dwell_d = DwellLoad;
               end
            end else begin
               dwell_d = dwell_q - DwellW'(1);
            end
         end
         GAP: begin
            if (gap_q != '0)     gap_d    = gap_q - GapW'(1);
            else if (pick_valid) do_grant = 1'b1;
            else                 state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (go_gap) begin
         state_d  = GAP;
         gap_d    = GapLoad;
         grant_d  = '0;
         blank_d  = 1'b1;
         digits_d = '0;
      end

      if (do_grant) begin
         state_d  = SHOW;
         ptr_d    = pick_idx;
         dwell_d  = DwellLoad;
         grant_d  = pick_gnt;
         blank_d  = 1'b0;
         switch_d = 1'b1;
         digits_d = frame_slice(frame_ext, 3'(pick_idx));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         ptr_q    <= IdxW'(N_SRC - 1);
         dwell_q  <= '0;
         gap_q    <= '0;
         grant_q  <= '0;
         blank_q  <= 1'b1;
         switch_q <= 1'b0;
         digits_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         dwell_q  <= dwell_d;
         gap_q    <= gap_d;
         grant_q  <= grant_d;
         blank_q  <= blank_d;
         switch_q <= switch_d;
         digits_q <= digits_d;
      end
   end

   assign d0_o     = digits_q[0];
   assign d1_o     = digits_q[1];
   assign d2_o     = digits_q[2];
   assign d3_o     = digits_q[3];
   assign grant_o  = grant_q;
   assign blank_o  = blank_q;
   assign switch_o = switch_q;

endmodule
